// File: rtl/pulse_pkg.sv
// pulse_pkg: channel state enum, clamp-to-1 helper and default counter widths for pulse_train_gen
package pulse_pkg;
  localparam int CNT_W_DEF = 35;
  localparam int NUM_W_DEF = 16;
  typedef enum logic [1:0] {IDLE, DELAY, HIGH, LOW} ch_state_e;
  function automatic logic [63:0] clamp1(input logic [63:0] v);
    return v == 64'd0 ? 64'd1 : v;
  endfunction
endpackage

// File: rtl/pulse_train_gen_if.sv
// pulse_train_gen_if: trigger/config inputs (master drives) and pulse/busy/done/launch_next outputs (slave drives)
interface pulse_train_gen_if import pulse_pkg::*; #(
  parameter int CH    = 4,
  parameter int CNT_W = CNT_W_DEF,
  parameter int NUM_W = NUM_W_DEF
);
  logic                trig_sel, start, launch, abort;
  logic [CH-1:0]       ch_en;
  logic [CH*CNT_W-1:0] delay, high, low;
  logic [CH*NUM_W-1:0] num;
  logic [CH-1:0]       pulse_out, busy, done;
  logic                launch_next;
  modport master(output trig_sel, start, launch, abort, ch_en, delay, high, low, num,
                 input pulse_out, busy, done, launch_next);
  modport slave(input trig_sel, start, launch, abort, ch_en, delay, high, low, num,
                output pulse_out, busy, done, launch_next);
endinterface

// File: rtl/pulse_chan.sv
// pulse_chan: one channel FSM; in accept/en/abort/config, out pulse_out/busy/done strobe
module pulse_chan import pulse_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF,
  parameter int NUM_W = NUM_W_DEF
) (
  input  logic             clk_Pulse,
  input  logic             rst,
  input  logic             abort,
  input  logic             accept,
  input  logic             en,
  input  logic [CNT_W-1:0] delay,
  input  logic [CNT_W-1:0] high,
  input  logic [CNT_W-1:0] low,
  input  logic [NUM_W-1:0] num,
  output logic             pulse_out,
  output logic             busy,
  output logic             done
);
  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, high_q, high_d, low_q, low_d;
  logic [NUM_W-1:0] rem_q, rem_d;
  logic             pulse_q, pulse_d, done_q, done_d, last;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    high_d  = high_q;
    low_d   = low_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    last    = cnt_q == CNT_W'(1);
    if (abort) state_d = IDLE;
    else case (state_q)
      IDLE: if (accept && en && num != '0) begin
        high_d  = CNT_W'(clamp1(64'(high)));
        low_d   = CNT_W'(clamp1(64'(low)));
        rem_d   = num;
        state_d = delay == '0 ? HIGH : DELAY;
        cnt_d   = delay == '0 ? high_d : delay;
      end
      DELAY: begin
        state_d = last ? HIGH : DELAY;
        cnt_d   = last ? high_q : cnt_q - 1'b1;
      end
      HIGH: if (last) begin
        state_d = rem_q == NUM_W'(1) ? IDLE : LOW;
        done_d  = rem_q == NUM_W'(1);
        rem_d   = rem_q - 1'b1;
        cnt_d   = low_q;
      end else cnt_d = cnt_q - 1'b1;
      LOW: begin
        state_d = last ? HIGH : LOW;
        cnt_d   = last ? high_q : cnt_q - 1'b1;
      end
    endcase
    pulse_d = state_d == HIGH;
  end
  always_ff @(posedge clk_Pulse) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      high_q  <= '0;
      low_q   <= '0;
      rem_q   <= '0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      high_q  <= high_d;
      low_q   <= low_d;
      rem_q   <= rem_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
    end
  end
  assign pulse_out = pulse_q;
  assign busy      = state_q != IDLE;
  assign done      = done_q;
endmodule

// File: rtl/pulse_train_gen.sv
// pulse_train_gen: multi-channel pulse-train generator; clk_Pulse/rst plus pulse_train_gen_if slave bus
module pulse_train_gen import pulse_pkg::*; #(
  parameter int CH    = 4,
  parameter int CNT_W = CNT_W_DEF,
  parameter int NUM_W = NUM_W_DEF
) (
  input logic              clk_Pulse,
  input logic              rst,
  pulse_train_gen_if.slave bus
);
  logic src, src_q, arm_q, arm_d, trig_q, trig_d, run_q, run_d, idle, accept;
  always_comb begin
    src    = bus.trig_sel ? bus.start : bus.launch;
    arm_d  = arm_q | ~src;
    trig_d = src & ~src_q & arm_q;
    idle   = ~|bus.busy;
    accept = trig_q & idle & ~bus.abort;
    run_d  = ~bus.abort & (accept | (run_q & ~idle));
  end
  always_ff @(posedge clk_Pulse) begin
    if (rst) begin
      src_q  <= 1'b0;
      arm_q  <= ~src;
      trig_q <= 1'b0;
      run_q  <= 1'b0;
    end else begin
      src_q  <= src;
      arm_q  <= arm_d;
      trig_q <= trig_d;
      run_q  <= run_d;
    end
  end
  assign bus.launch_next = run_q & idle;
  for (genvar i = 0; i < CH; i++) begin : g_ch
    pulse_chan #(.CNT_W(CNT_W), .NUM_W(NUM_W)) u_chan (
      .clk_Pulse (clk_Pulse),
      .rst       (rst),
      .abort     (bus.abort),
      .accept    (accept),
      .en        (bus.ch_en[i]),
      .delay     (bus.delay[i*CNT_W +: CNT_W]),
      .high      (bus.high[i*CNT_W +: CNT_W]),
      .low       (bus.low[i*CNT_W +: CNT_W]),
      .num       (bus.num[i*NUM_W +: NUM_W]),
      .pulse_out (bus.pulse_out[i]),
      .busy      (bus.busy[i]),
      .done      (bus.done[i])
    );
  end
endmodule

// File: tb/tb_pulse_train_gen.sv
// tb_pulse_train_gen: table-driven vectors plus hand-written corner sequences for pulse_train_gen
module tb_pulse_train_gen;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  pulse_train_gen_if #(.CH(4), .CNT_W(35), .NUM_W(16)) bus();
  pulse_train_gen #(.CH(4), .CNT_W(35), .NUM_W(16)) dut (
    .clk_Pulse (clk),
    .rst       (rst),
    .bus       (bus.slave)
  );
  typedef struct packed {
    logic            sel;
    logic [3:0]      en;
    logic [3:0][7:0] d, h, l, n;
    logic [7:0]      ln;
    logic [3:0]      dn;
  } vec_t;
  vec_t tv [5];
  int total = 0;
  int bad = 0;
  logic [3:0][31:0] pm;
  logic [3:0]       dm, b1;
  int               lnc, lnk, dcnt;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] exp_mask(input int d, input int h, input int l, input int n);
    logic [31:0] m = '0;
    int k = 1 + d;
    int hh = h == 0 ? 1 : h;
    int ll = l == 0 ? 1 : l;
    for (int p = 0; p < n; p++) begin
      for (int j = 0; j < hh; j++) begin
        if (k < 32) m[k] = 1'b1;
        k++;
      end
      if (p < n - 1) k += ll;
    end
    return m;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic cfg(input vec_t v);
    bus.trig_sel = v.sel;
    bus.ch_en    = v.en;
    for (int i = 0; i < 4; i++) begin
      bus.delay[i*35 +: 35] = 35'(v.d[i]);
      bus.high[i*35 +: 35]  = 35'(v.h[i]);
      bus.low[i*35 +: 35]   = 35'(v.l[i]);
      bus.num[i*16 +: 16]   = 16'(v.n[i]);
    end
  endtask
  task automatic fire(input logic sel);
    if (sel) bus.start = 1'b1;
    else bus.launch = 1'b1;
  endtask
  task automatic capture(input int w, input bit drop, input int rk);
    pm = '0; dm = '0; b1 = '0; lnc = 0; lnk = -1; dcnt = 0;
    for (int k = 0; k < w; k++) begin
      tick();
      for (int i = 0; i < 4; i++) pm[i][k] = bus.pulse_out[i];
      dm |= bus.done;
      dcnt += $countones(bus.done);
      if (bus.launch_next) begin
        lnc++;
        if (lnk < 0) lnk = k;
      end
      if (k == 1) b1 = bus.busy;
      if (k == 0 && drop) begin
        bus.start = 1'b0;
        bus.launch = 1'b0;
      end
      if (k == rk) bus.start = 1'b1;
      if (k == rk + 2) bus.start = 1'b0;
    end
  endtask
  initial begin
    int any;
    logic [3:0] be;
    tv[0] = '{sel:1'b1, en:4'b0001, d:{8'd0,8'd0,8'd0,8'd2}, h:{8'd0,8'd0,8'd0,8'd3},
              l:{8'd0,8'd0,8'd0,8'd1}, n:{8'd0,8'd0,8'd0,8'd2}, ln:8'd10, dn:4'b0001};
    tv[1] = '{sel:1'b1, en:4'b0111, d:{8'd3,8'd10,8'd5,8'd0}, h:{8'd2,8'd2,8'd2,8'd2},
              l:{8'd1,8'd1,8'd1,8'd1}, n:{8'd1,8'd1,8'd1,8'd1}, ln:8'd13, dn:4'b0111};
    tv[2] = '{sel:1'b1, en:4'b0011, d:{8'd0,8'd0,8'd0,8'd0}, h:{8'd0,8'd0,8'd2,8'd0},
              l:{8'd0,8'd0,8'd1,8'd0}, n:{8'd0,8'd0,8'd0,8'd3}, ln:8'd6, dn:4'b0001};
    tv[3] = '{sel:1'b1, en:4'b0000, d:{8'd1,8'd1,8'd1,8'd1}, h:{8'd1,8'd1,8'd1,8'd1},
              l:{8'd1,8'd1,8'd1,8'd1}, n:{8'd1,8'd1,8'd1,8'd1}, ln:8'd1, dn:4'b0000};
    tv[4] = '{sel:1'b0, en:4'b1010, d:{8'd3,8'd0,8'd1,8'd0}, h:{8'd2,8'd0,8'd1,8'd0},
              l:{8'd1,8'd0,8'd2,8'd0}, n:{8'd1,8'd0,8'd2,8'd0}, ln:8'd6, dn:4'b1010};
    rst = 1'b1;
    bus.start = 1'b0; bus.launch = 1'b0; bus.abort = 1'b0;
    cfg(tv[0]);
    repeat (3) tick();
    chk("rst_pulse", 64'(bus.pulse_out), 0);
    chk("rst_busy", 64'(bus.busy), 0);
    chk("rst_done", 64'(bus.done), 0);
    chk("rst_ln", 64'(bus.launch_next), 0);
    rst = 1'b0;
    repeat (2) tick();
    for (int v = 0; v < 5; v++) begin
      cfg(tv[v]);
      fire(tv[v].sel);
      capture(24, 1'b1, -1);
      for (int i = 0; i < 4; i++)
        chk($sformatf("v%0d_pulse%0d", v, i), 64'(pm[i]),
            tv[v].en[i] ? 64'(exp_mask(tv[v].d[i], tv[v].h[i], tv[v].l[i], tv[v].n[i])) : 64'd0);
      for (int i = 0; i < 4; i++) be[i] = tv[v].en[i] && tv[v].n[i] != 0;
      chk($sformatf("v%0d_busy1", v), 64'(b1), 64'(be));
      chk($sformatf("v%0d_ln_at", v), 64'(lnk), 64'(tv[v].ln));
      chk($sformatf("v%0d_ln_cnt", v), 64'(lnc), 1);
      chk($sformatf("v%0d_done", v), 64'(dm), 64'(tv[v].dn));
      chk($sformatf("v%0d_done_cnt", v), 64'(dcnt), 64'($countones(tv[v].dn)));
      repeat (2) tick();
    end
    cfg(tv[0]);
    bus.trig_sel = 1'b0;
    bus.start = 1'b1;
    any = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (k == 1) bus.start = 1'b0;
      if (bus.busy != 0 || bus.launch_next) any++;
    end
    chk("sel_ignore", 64'(any), 0);
    bus.trig_sel = 1'b1;
    bus.start = 1'b1;
    capture(30, 1'b0, -1);
    chk("level_pulses", 64'($countones(pm[0])), 6);
    chk("level_ln_cnt", 64'(lnc), 1);
    bus.start = 1'b0;
    repeat (2) tick();
    fire(1'b1);
    capture(24, 1'b1, 3);
    chk("retrig_pulse", 64'(pm[0]), 64'(exp_mask(2, 3, 1, 2)));
    chk("retrig_ln_cnt", 64'(lnc), 1);
    repeat (2) tick();
    fire(1'b1);
    capture(24, 1'b1, -1);
    chk("fresh_busy1", 64'(b1[0]), 1);
    chk("fresh_pulse", 64'(pm[0]), 64'(exp_mask(2, 3, 1, 2)));
    repeat (2) tick();
    fire(1'b1);
    any = 0;
    for (int k = 0; k < 24; k++) begin
      tick();
      if (k == 0) bus.start = 1'b0;
      if (k == 4) begin
        chk("abort_pre_high", 64'(bus.pulse_out[0]), 1);
        bus.abort = 1'b1;
      end
      if (k == 5) begin
        bus.abort = 1'b0;
        chk("abort_pulse", 64'(bus.pulse_out), 0);
        chk("abort_busy", 64'(bus.busy), 0);
      end
      if (bus.done != 0 || bus.launch_next) any++;
    end
    chk("abort_no_strobe", 64'(any), 0);
    fire(1'b1);
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("rstmid_pulse", 64'(bus.pulse_out), 0);
    chk("rstmid_busy", 64'(bus.busy), 0);
    any = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.busy != 0 || bus.pulse_out != 0 || bus.launch_next) any++;
    end
    chk("rstmid_held_no_run", 64'(any), 0);
    bus.start = 1'b0;
    tick();
    fire(1'b1);
    capture(24, 1'b1, -1);
    chk("rstmid_rerun_busy1", 64'(b1[0]), 1);
    chk("rstmid_rerun_pulse", 64'(pm[0]), 64'(exp_mask(2, 3, 1, 2)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pulse_train_gen.md
# pulse_train_gen

Multi-channel programmable pulse-train generator, the parametrised successor to the single-pulse generator in the synchronizing-pulse chain. On one trigger, selected either from the internal start line or the external launch line, each of `CH` channels waits its own delay, then emits `N` pulses with programmable high and low durations. When every channel finishes, the block issues a one-cycle `launch_next` strobe to start the next stage of the delay-line chain.

## Interface
- `CH`, default 4: number of output channels (1..16).
- `CNT_W`, default 35: width of the delay, high and low duration counters.
- `NUM_W`, default 16: width of the pulse-count field.

- `clk_Pulse` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `trig_sel` in 1: 1 selects `start`, 0 selects `launch`.
- `start` in 1: internal trigger level.
- `launch` in 1: external trigger level.
- `abort` in 1: synchronous abort of any run in progress.
- `ch_en` in CH: per-channel enable, latched at trigger.
- `delay` in CH*CNT_W: per-channel delay; channel i uses `[i*CNT_W +: CNT_W]`.
- `high` in CH*CNT_W: per-channel high time in cycles.
- `low` in CH*CNT_W: per-channel low time in cycles.
- `num` in CH*NUM_W: per-channel pulse count.
- `pulse_out` out CH: registered pulse outputs.
- `busy` out CH: channel is running.
- `done` out CH: one-cycle strobe when a channel completes.
- `launch_next` out 1: one-cycle strobe when the whole run completes.

## Operation
- Trigger source: `src = trig_sel ? start : launch`. `src` is registered into `src_q`. A trigger is the rising edge `src & ~src_q`, which is the registered `trig` in cycle T.
- A trigger is accepted only when all channels are IDLE. Triggers that arrive while any channel is `busy` are ignored, and are not queued.
- At an accepted trigger, each enabled channel latches `delay`, `high`, `low` and `num`. Inputs may change freely afterwards without affecting the run.
- Channel FSM states: IDLE, DELAY, HIGH, LOW.
  - IDLE → DELAY on an accepted trigger when `ch_en[i]`=1 and `num`≠0.
  - DELAY → HIGH after D cycles. With D=0, DELAY lasts 0 cycles.
  - HIGH → LOW after H cycles, if pulses remain.
  - HIGH → IDLE after H cycles on the last pulse, with `done[i]` strobed.
  - LOW → HIGH after L cycles.
- Clamping:
  - H=0 is treated as H=1.
  - L=0 is treated as L=1.
  - D has no clamp.
- Channels with `ch_en[i]`=0, or with `num`=0, stay IDLE. They never pulse and never strobe `done`. They count as finished for `launch_next`.
- `launch_next`:
  - Strobes for one cycle in the first cycle in which all channels are IDLE after an accepted trigger.
  - If no channel is active in a run, it strobes in cycle T+1.
  - It is suppressed after `abort`.
- `abort`=1:
  - All channels go to IDLE on the next edge and `pulse_out` drops.
  - No `done` or `launch_next` strobes are produced.
  - `abort` takes priority over a simultaneous trigger.
- `rst`: clears `src_q`, all FSMs and all counters. A `src` level held high through reset does not trigger until it falls and rises again.
- Counters are unsigned `CNT_W`/`NUM_W`. The maximum values (2^CNT_W−1 and 2^NUM_W−1) run to completion without wrapping.

## Timing
- Reset values: `pulse_out`=0, `busy`=0, `done`=0, `launch_next`=0.
- With the trigger in cycle T:
  - `busy[i]` is high from T+1.
  - The first high cycle is T+1+D.
  - Each pulse is high for exactly H cycles, and the gaps are exactly L cycles.
  - There is no trailing low after the last pulse.
- With the last high cycle at E:
  - `busy[i]` falls in cycle E+1.
  - `done[i]` is high in E+1 only.
- `launch_next` is high in the cycle in which the last `busy` bit falls.
- Latency from a rising `src` to `trig` is 1 cycle, so the first `pulse_out` edge comes 2+D cycles after the input edge.

## Structure
- Package `pulse_pkg` holds:
  - the channel state enum (IDLE, DELAY, HIGH, LOW);
  - the clamp-to-1 function;
  - the default `CNT_W`/`NUM_W` constants.
- Sub-module `pulse_chan` implements one channel FSM with its latched config and counters.
- The top level is instantiated through `generate` over `CH`. The top level owns the edge detect, trigger acceptance, `abort` fan-out and `launch_next`.

## Test plan
- Basic run: CH=1, `trig_sel`=1, D=2, H=3, L=1, N=2, trigger at T=10 → `pulse_out` high in cycles 13–15 and 17–19, `done` and `launch_next` in cycle 20.
- Source select: `trig_sel`=0, pulse `start` → no activity. Then pulse `launch` → a run occurs. A level held high across the run triggers only once.
- Multi-channel skew: channel delays 0/5/10, H=2, N=1, channel 3 disabled → channels 0–2 pulse at T+1, T+6 and T+11. `launch_next` strobes at T+13 only.
- Clamp and skip: H=0, L=0, N=3 → pattern 1,0,1,0,1. A channel with `num`=0 shows no `busy` and no `done`. An all-disabled run gives `launch_next` at T+1.
- Retrigger: a second edge during a run is ignored and the output matches a single run. An edge after `launch_next` starts a fresh run.
- Abort and reset: `abort` during HIGH → `pulse_out` is 0 next cycle, with no `done` or `launch_next`. `rst` mid-run with `src` held high → all outputs 0, and no new run until `src` falls and rises.
